regfile_wb: RTL
===============

// Module: regfile_wb
// PURPOSE
// - Register file and write-back sink for the single-cycle CPU: consumes the write-register
//   number and data-select produced by the JAL destination logic, muxes ALU result vs PC+4,
//   commits to a 32x32 register array on the clock edge.
// - Supplies two combinational operand read ports (rs/rt) and one debug read port; counts committed writes.
// PARAMETERS
// - XLEN    32  data width of each register
// - NREG    32  number of architectural registers (address width = $clog2(NREG) = 5)
// - CNT_W   32  width of committed-write counter
// PORTS
// - clk       in   1      system clock, rising edge
// - rst       in   1      asynchronous reset, active-high
// - we        in   1      register write enable from control (wreg)
// - wn        in   5      destination register number (31 when JAL)
// - dsel      in   1      write-data select: 0 = alu_res, 1 = pc4
// - alu_res   in   XLEN   ALU / memory result
// - pc4       in   XLEN   PC+4 link value
// - rna       in   5      read port A register number
// - rnb       in   5      read port B register number
// - dbg_rn    in   5      debug read register number
// - qa        out  XLEN   read data A
// - qb        out  XLEN   read data B
// - dbg_q     out  XLEN   debug read data
// - wr_count  out  CNT_W  number of committed writes since reset
// BEHAVIOUR
// - Reset (async, rst=1): all NREG registers <= 0, wr_count <= 0 immediately, independent of clk;
//   qa/qb/dbg_q therefore read 0. Writes are blocked while rst=1.
// - Write data: wdata = dsel ? pc4 : alu_res (combinational, full XLEN, no extension).
// - Commit: at rising clk edge with rst=0, if we=1 and wn!=0: reg[wn] <= wdata,
//   wr_count <= wr_count + 1 (wraps modulo 2^CNT_W, no saturation).
// - wn==0 with we=1: no state change, wr_count unchanged; r0 is always 0.
// - we=0: no state change regardless of wn/dsel.
// - Reads: qa=reg[rna], qb=reg[rnb], dbg_q=reg[dbg_rn], purely combinational from stored state;
//   rn==0 returns 0.
// - NO write-to-read bypass: alu_res depends on qa/qb in the same cycle, so a bypass would form a
//   combinational loop. Read of register being written returns old value until the edge, new value after.
// - Latency: write visible on read ports one clk edge after being presented; read latency zero.
// - rst asserted mid-cycle while a write is pending: reset wins, register and counter stay 0;
//   write on first edge after rst deasserts proceeds normally.
// - dsel with we=0 or wn==0 has no effect.
// STRUCTURE
// - cpu_pkg: XLEN, NREG, REG_W=5, REG_ZERO=5'd0, REG_RA=5'd31 constants (shared with control / JAL mux).
// - Sub-module regfile_rport (array + rn -> q, zero-forcing for r0), instantiated 3x (A, B, debug).
// - Top holds: write-data mux, register array (always @(posedge clk or posedge rst)), wr_count.
// TESTING
// - Reset: preload via writes, pulse rst between edges -> all qa/qb/dbg_q reads 0, wr_count=0 at once.
// - ALU write: we=1,wn=5,dsel=0,alu_res=32'hDEADBEEF,pc4=32'h00000104 -> after edge rna=5 gives DEADBEEF, wr_count=1.
// - JAL link: we=1,wn=31,dsel=1,pc4=32'h00400010,alu_res=32'h12345678 -> reg[31]=00400010, wr_count+1.
// - r0 write: we=1,wn=0,alu_res=32'hFFFFFFFF -> rna=0 reads 0, wr_count unchanged; we=0,wn=7 -> reg[7] unchanged.
// - Read-during-write: reg[9]=1, write 2 to r9 with rna=9 -> qa=1 before edge, qa=2 after; no X/loop.
// - Counter wrap (CNT_W=4 build): 16 valid writes -> wr_count returns to 0; rst mid-cycle with we=1 -> no write.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared constants for the single-cycle CPU datapath. The register file,
// the control unit and the JAL destination mux all take these values from here.
//   XLEN     : data width of each architectural register
//   NREG     : number of architectural registers
//   REG_W    : width of a register number
//   CNT_W    : default width of the committed-write counter
//   REG_ZERO : hard-wired zero register
//   REG_RA   : return-address register, the destination of a JAL link
package cpu_pkg;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int REG_W = 5;
    localparam int CNT_W = 32;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_W-1:0] REG_RA   = 5'd31;

endpackage : cpu_pkg

// File: rtl/regfile_rport.sv
// regfile_rport
// One combinational read port of the register file. It selects a register from
// the flattened register array, and register number 0 always reads as zero.
// Ports:
//   regs_i : all registers, packed as [NUM_REGS-1:0][DATA_W-1:0]
//   rn_i   : register number to read
//   q_o    : read data (zero when rn_i == REG_ZERO)
module regfile_rport
    import cpu_pkg::*;
#(
    parameter int DATA_W   = XLEN,
    parameter int NUM_REGS = NREG,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic [NUM_REGS-1:0][DATA_W-1:0] regs_i,
    input  logic [AW-1:0]                   rn_i,
    output logic [DATA_W-1:0]               q_o
);

    // r0 is forced to zero here, even though the array slot is also tied low.
    // This keeps the read port correct on its own.
    always_comb begin
        q_o = regs_i[rn_i];
        if (rn_i == AW'(REG_ZERO)) begin
            q_o = '0;
        end
    end

endmodule : regfile_rport

// File: rtl/regfile_wb.sv
// regfile_wb
// Register file and write-back sink for the single-cycle CPU. The write data
// is the ALU result or PC+4, chosen by dsel. The selected value is committed
// to register wn on the rising edge of clk when we=1 and wn != 0. There are two
// operand read ports (qa/qb) and one debug read port, and all three are purely
// combinational. wr_count counts committed writes since the last reset and
// wraps around.
// Ports:
//   clk, rst           : clock (rising edge) and asynchronous active-high reset
//   we, wn, dsel       : write enable, destination register, data select (1 = pc4)
//   alu_res, pc4       : write-data candidates
//   rna, rnb, dbg_rn   : read register numbers
//   qa, qb, dbg_q      : read data
//   wr_count           : number of committed writes
module regfile_wb #(
    parameter int XLEN  = cpu_pkg::XLEN,
    parameter int NREG  = cpu_pkg::NREG,
    parameter int CNT_W = cpu_pkg::CNT_W,
    localparam int AW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    wn,
    input  logic             dsel,
    input  logic [XLEN-1:0]  alu_res,
    input  logic [XLEN-1:0]  pc4,
    input  logic [AW-1:0]    rna,
    input  logic [AW-1:0]    rnb,
    input  logic [AW-1:0]    dbg_rn,
    output logic [XLEN-1:0]  qa,
    output logic [XLEN-1:0]  qb,
    output logic [XLEN-1:0]  dbg_q,
    output logic [CNT_W-1:0] wr_count
);

    import cpu_pkg::*;

    logic [XLEN-1:0]            wdata;
    logic                       wr_en;
    logic [NREG-1:0][XLEN-1:0]  regs;
    logic [CNT_W-1:0]           cnt_q;
    logic [CNT_W-1:0]           cnt_d;

    assign wdata = dsel ? pc4 : alu_res;

    // A write to r0 is discarded completely, so it does not bump the counter either.
    assign wr_en = we && (wn != AW'(REG_ZERO));

    // Each register is a separate flop bank so that reset can clear all of them
    // asynchronously. r0 is a constant and holds no storage.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_regs
            if (gi == 0) begin : g_zero
                assign regs[gi] = '0;
            end else begin : g_reg
                logic [XLEN-1:0] r_q;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_q <= '0;
                    end else if (wr_en && (wn == AW'(gi))) begin
                        r_q <= wdata;
                    end
                end
                assign regs[gi] = r_q;
            end
        end
    endgenerate

    assign cnt_d = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (wr_en) begin
            cnt_q <= cnt_d;
        end
    end

    assign wr_count = cnt_q;

    // The read ports read stored state only. There is deliberately no bypass
    // from wdata: alu_res is derived from qa/qb in the same cycle, so a bypass
    // would close a combinational loop.
    regfile_rport #(.DATA_W(XLEN), .NUM_REGS(NREG)) u_rport_a (
        .regs_i (regs),
        .rn_i   (rna),
        .q_o    (qa)
    );

    regfile_rport #(.DATA_W(XLEN), .NUM_REGS(NREG)) u_rport_b (
        .regs_i (regs),
        .rn_i   (rnb),
        .q_o    (qb)
    );

    regfile_rport #(.DATA_W(XLEN), .NUM_REGS(NREG)) u_rport_dbg (
        .regs_i (regs),
        .rn_i   (dbg_rn),
        .q_o    (dbg_q)
    );

endmodule : regfile_wb
